// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: shared types and sizing helpers for the instruction-fetch sequencer.
// The optional RV_FETCH_PERF_EN feature lives in rv_fetch_ctrl; nothing here depends on it.
package rv_fetch_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    BOOT = 2'd0,  // load the reset PC
    IDLE = 2'd1,  // no request outstanding
    WAIT = 2'd2,  // request outstanding, data will be kept
    DROP = 2'd3   // request outstanding, data is stale and will be discarded
  } fetch_state_e;

  // Default-width fetch buffer entry (64-bit PC, 64-bit word)
  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] word;
  } fetch_entry_t;

  // Bytes covered by one memory word, i.e. the PC increment per fetch
  function automatic int unsigned fetch_step(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // Number of PC bits below word alignment
  function automatic int unsigned fetch_off_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/rv_fetch_fifo.sv
// rv_fetch_fifo: small synchronous FIFO of fetch entries with flush.
// Head is read combinationally so decode sees the word in the cycle it becomes valid.
module rv_fetch_fifo
  import rv_fetch_pkg::*;
#(
  parameter type         entry_t = fetch_entry_t,
  parameter int unsigned DEPTH   = 4,
  localparam int unsigned PTR_W  = $clog2(DEPTH),
  localparam int unsigned CNT_W  = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  entry_t           entry_i,
  input  logic             pop_i,
  output entry_t           head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             push_fire;
  logic             pop_fire;

  assign full_o  = (count_reg == CNT_W'(DEPTH));
  assign empty_o = (count_reg == '0);
  assign count_o = count_reg;
  assign head_o  = mem[rd_ptr_reg];

  // A flush discards everything, including whatever is pushed or popped that cycle;
  // a pop frees a slot for a push in the same cycle even when full.
  assign pop_fire  = pop_i && !empty_o && !flush_i;
  assign push_fire = push_i && !flush_i && (!full_o || pop_fire);

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push_fire) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop_fire)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      if (push_fire && !pop_fire)      count_next = count_reg + CNT_W'(1);
      else if (pop_fire && !push_fire) count_next = count_reg - CNT_W'(1);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk_i) begin
    if (push_fire) mem[wr_ptr_reg] <= entry_i;
  end

endmodule

// File: rtl/rv_fetch_ctrl.sv
// rv_fetch_ctrl: instruction-fetch sequencer between the imem port and decode.
// Owns the fetch PC, runs a one-outstanding imem req/ack handshake and buffers
// returned words with their PC in rv_fetch_fifo.
// Optional macro RV_FETCH_PERF_EN adds saturating stall and flush counters.
module rv_fetch_ctrl
  import rv_fetch_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = 64,
  parameter int unsigned MEM_DATA_WIDTH = 64,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  input  logic [MEM_ADDR_WIDTH-1:0] boot_addr_i,
  input  logic                      redirect_i,
  input  logic [MEM_ADDR_WIDTH-1:0] redirect_addr_i,
  output logic                      imem_req_o,
  output logic [MEM_ADDR_WIDTH-1:0] imem_addr_o,
  input  logic [MEM_DATA_WIDTH-1:0] imem_data_i,
  input  logic                      imem_ack_i,
  output logic                      instr_valid_o,
  output logic [MEM_DATA_WIDTH-1:0] instr_o,
  output logic [MEM_ADDR_WIDTH-1:0] instr_pc_o,
`ifdef RV_FETCH_PERF_EN
  output logic [31:0]               fetch_stall_cnt_o,
  output logic [31:0]               fetch_flush_cnt_o,
`endif
  input  logic                      instr_ready_i
);

  localparam int unsigned STEP  = fetch_step(MEM_DATA_WIDTH);
  localparam int unsigned OFF_W = fetch_off_w(MEM_DATA_WIDTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [MEM_ADDR_WIDTH-1:0] STEP_A = MEM_ADDR_WIDTH'(STEP);

  typedef struct packed {
    logic [MEM_ADDR_WIDTH-1:0] pc;
    logic [MEM_DATA_WIDTH-1:0] word;
  } entry_t;

  // Clear the byte-offset bits so the PC always names a whole memory word
  function automatic logic [MEM_ADDR_WIDTH-1:0] align_pc(input logic [MEM_ADDR_WIDTH-1:0] a);
    logic [MEM_ADDR_WIDTH-1:0] r;
    r            = a;
    r[OFF_W-1:0] = '0;
    return r;
  endfunction

  fetch_state_e              state_reg, state_next;
  logic [MEM_ADDR_WIDTH-1:0] pc_reg, pc_next;
  logic [MEM_ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic                      push_req;
  entry_t                    push_entry;
  entry_t                    fifo_head;
  entry_t                    hold_reg;
  logic [CNT_W-1:0]          fifo_count;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_push;
  logic                      fifo_pop;

  // Next-state, PC and request address; redirect overrides every state
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    addr_next  = addr_reg;
    push_req   = 1'b0;
    case (state_reg)
      BOOT: begin
        pc_next    = align_pc(boot_addr_i);
        state_next = IDLE;
      end
      IDLE: begin
        // Nothing is outstanding here, so free space is just depth minus count
        if (fifo_count < CNT_W'(FIFO_DEPTH)) begin
          addr_next  = pc_reg;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack_i) begin
          push_req   = 1'b1;
          pc_next    = pc_reg + STEP_A;
          state_next = IDLE;
        end
      end
      DROP: begin
        if (imem_ack_i) state_next = IDLE;
      end
      default: state_next = BOOT;
    endcase

    if (redirect_i) begin
      push_req = 1'b0;
      pc_next  = align_pc(redirect_addr_i);
      if (state_reg == WAIT || state_reg == DROP) begin
        // The in-flight request must still complete on the bus, but its data is stale
        state_next = imem_ack_i ? IDLE : DROP;
      end else begin
        // Do not launch a request from the old PC in the redirect cycle
        state_next = IDLE;
        addr_next  = addr_reg;
      end
    end
  end

  // FSM, PC and latched request address
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_reg <= BOOT;
      pc_reg    <= '0;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      addr_reg  <= addr_next;
    end
  end

  // Request is high for the whole outstanding window including the ack cycle;
  // the address is latched at issue so it stays stable even after a redirect.
  assign imem_req_o  = (state_reg == WAIT) || (state_reg == DROP);
  assign imem_addr_o = addr_reg;

  assign push_entry.pc   = pc_reg;
  assign push_entry.word = imem_data_i;
  // The space check guarantees room; the full guard only keeps the buffer safe
  assign fifo_push = push_req && !fifo_full;
  assign fifo_pop  = instr_ready_i && !redirect_i;

  rv_fetch_fifo #(
    .entry_t (entry_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .flush_i (redirect_i),
    .push_i  (fifo_push),
    .entry_i (push_entry),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Remember the last head shown so the word/PC outputs hold while empty
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) hold_reg <= '0;
    else if (!fifo_empty) hold_reg <= fifo_head;
  end

  assign instr_valid_o = !fifo_empty;
  assign instr_o       = fifo_empty ? hold_reg.word : fifo_head.word;
  assign instr_pc_o    = fifo_empty ? hold_reg.pc   : fifo_head.pc;

`ifdef RV_FETCH_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;

  // Saturating counters: decode starved, and redirect cycles
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (instr_ready_i && fifo_empty && stall_cnt_reg != '1)
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (redirect_i && flush_cnt_reg != '1)
        flush_cnt_reg <= flush_cnt_reg + 32'd1;
    end
  end

  assign fetch_stall_cnt_o = stall_cnt_reg;
  assign fetch_flush_cnt_o = flush_cnt_reg;
`endif

`ifdef SIMULATION
  // An ack with nothing outstanding is a bus protocol violation; the FSM ignores it
  always_ff @(posedge clk_i) begin
    if (arst_ni && imem_ack_i)
      assert (state_reg == WAIT || state_reg == DROP)
        else $error("imem_ack_i with no request outstanding");
  end
`endif

endmodule

// File: tb/tb_rv_fetch_ctrl.sv
// tb_rv_fetch_ctrl: directed self-checking bench for rv_fetch_ctrl.
// A behavioural imem answers each request after a programmable number of request cycles.
module tb_rv_fetch_ctrl;

  logic        clk_i = 1'b0;
  logic        arst_ni;
  logic [63:0] boot_addr_i;
  logic        redirect_i;
  logic [63:0] redirect_addr_i;
  logic        imem_req_o;
  logic [63:0] imem_addr_o;
  logic [63:0] imem_data_i;
  logic        imem_ack_i;
  logic        instr_valid_o;
  logic [63:0] instr_o;
  logic [63:0] instr_pc_o;
  logic        instr_ready_i;
`ifdef RV_FETCH_PERF_EN
  logic [31:0] fetch_stall_cnt_o;
  logic [31:0] fetch_flush_cnt_o;
`endif

  int          checks = 0;
  int          errors = 0;
  int          mem_lat = 1;
  int          mem_cyc = 0;
  int          flush_total = 0;
  logic        req_prev = 1'b0;
  logic [63:0] issue_q[$];

  always #5 clk_i = ~clk_i;

  rv_fetch_ctrl dut (
    .clk_i           (clk_i),
    .arst_ni         (arst_ni),
    .boot_addr_i     (boot_addr_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_data_i     (imem_data_i),
    .imem_ack_i      (imem_ack_i),
    .instr_valid_o   (instr_valid_o),
    .instr_o         (instr_o),
    .instr_pc_o      (instr_pc_o),
`ifdef RV_FETCH_PERF_EN
    .fetch_stall_cnt_o (fetch_stall_cnt_o),
    .fetch_flush_cnt_o (fetch_flush_cnt_o),
`endif
    .instr_ready_i   (instr_ready_i)
  );

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return {~a[31:0], a[31:0]} ^ 64'h0123_4567_89ab_cdef;
  endfunction

  // imem model: ack arrives in the mem_lat-th cycle that req is high
  always begin
    @(posedge clk_i);
    #2;
    if (!arst_ni) begin
      imem_ack_i = 1'b0;
      mem_cyc    = 0;
    end else if (imem_req_o && !imem_ack_i) begin
      mem_cyc = mem_cyc + 1;
      if (mem_cyc >= mem_lat) begin
        imem_ack_i  = 1'b1;
        imem_data_i = mem_word(imem_addr_o);
        mem_cyc     = 0;
      end
    end else begin
      imem_ack_i = 1'b0;
      mem_cyc    = 0;
    end
  end

  // Record the address of every newly issued request
  always begin
    @(posedge clk_i);
    #3;
    if (imem_req_o && !req_prev) issue_q.push_back(imem_addr_o);
    req_prev = imem_req_o;
  end

  task automatic wait_issues(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (issue_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (instr_valid_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
  endtask

  task automatic do_redirect(input logic [63:0] a);
    redirect_i      = 1'b1;
    redirect_addr_i = a;
    @(negedge clk_i);
    redirect_i  = 1'b0;
    flush_total = flush_total + 1;
    issue_q.delete();
  endtask

  task automatic test_reset;
    arst_ni         = 1'b0;
    boot_addr_i     = 64'h0000_0000_8000_0004;
    redirect_i      = 1'b0;
    redirect_addr_i = '0;
    imem_ack_i      = 1'b0;
    imem_data_i     = '0;
    instr_ready_i   = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req_o); end
    checks++; if (imem_addr_o !== 64'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", imem_addr_o); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", instr_valid_o); end
    checks++; if (instr_o !== 64'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instr_o); end
    checks++; if (instr_pc_o !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", instr_pc_o); end
`ifdef RV_FETCH_PERF_EN
    checks++; if (fetch_stall_cnt_o !== 32'h0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", fetch_stall_cnt_o); end
    checks++; if (fetch_flush_cnt_o !== 32'h0) begin errors++; $display("FAIL reset_flush_cnt: got %0d expected 0", fetch_flush_cnt_o); end
`endif
    arst_ni = 1'b1;
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_boot;
    bit          ok;
    logic [63:0] exp_pc;
    mem_lat       = 1;
    instr_ready_i = 1'b0;
    wait_issues(2, 20, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL boot_issue_timeout: got %0d requests expected 2", issue_q.size());
    end else begin
      checks++; if (issue_q[0] !== 64'h8000_0000) begin errors++; $display("FAIL boot_addr0: got %h expected 0000000080000000", issue_q[0]); end
      checks++; if (issue_q[1] !== 64'h8000_0008) begin errors++; $display("FAIL boot_addr1: got %h expected 0000000080000008", issue_q[1]); end
    end
    for (int k = 0; k < 3; k++) begin
      exp_pc = 64'h8000_0000 + 64'(8 * k);
      wait_valid(20, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL boot_valid_timeout: word %0d never valid", k);
      end else begin
        checks++; if (instr_pc_o !== exp_pc) begin errors++; $display("FAIL boot_pc: got %h expected %h", instr_pc_o, exp_pc); end
        checks++; if (instr_o !== mem_word(exp_pc)) begin errors++; $display("FAIL boot_word: got %h expected %h", instr_o, mem_word(exp_pc)); end
      end
      instr_ready_i = 1'b1;
      @(negedge clk_i);
      instr_ready_i = 1'b0;
    end
    $display("test_boot done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_backpressure;
    instr_ready_i = 1'b0;
    mem_lat       = 2;
    do_redirect(64'h2000);
    repeat (40) @(negedge clk_i);
    checks++; if (issue_q.size() != 4) begin errors++; $display("FAIL bp_req_count: got %0d expected 4", issue_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (issue_q.size() > i) begin
        checks++;
        if (issue_q[i] !== 64'h2000 + 64'(8 * i)) begin
          errors++; $display("FAIL bp_addr: got %h expected %h", issue_q[i], 64'h2000 + 64'(8 * i));
        end
      end
    end
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL bp_req_idle: got %b expected 0", imem_req_o); end
    checks++; if (instr_pc_o !== 64'h2000) begin errors++; $display("FAIL bp_head_pc: got %h expected 0000000000002000", instr_pc_o); end
    instr_ready_i = 1'b1;
    @(negedge clk_i);
    instr_ready_i = 1'b0;
    repeat (20) @(negedge clk_i);
    checks++; if (issue_q.size() != 5) begin errors++; $display("FAIL bp_req_after_pop: got %0d expected 5", issue_q.size()); end
    if (issue_q.size() > 4) begin
      checks++; if (issue_q[4] !== 64'h2020) begin errors++; $display("FAIL bp_addr_after_pop: got %h expected 0000000000002020", issue_q[4]); end
    end
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL bp_req_idle2: got %b expected 0", imem_req_o); end
    checks++; if (instr_pc_o !== 64'h2008) begin errors++; $display("FAIL bp_head_pc2: got %h expected 0000000000002008", instr_pc_o); end
    $display("test_backpressure done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_redirect_inflight;
    bit ok;
    instr_ready_i = 1'b0;
    mem_lat       = 4;
    do_redirect(64'h3000);
    wait_issues(3, 60, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rdi_issue_timeout: got %0d requests expected 3", issue_q.size());
    end
    checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL rdi_valid_before: got %b expected 1", instr_valid_o); end
    do_redirect(64'h1004);
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rdi_flush: got %b expected 0", instr_valid_o); end
    checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL rdi_req_held: got %b expected 1", imem_req_o); end
    checks++; if (imem_addr_o !== 64'h3010) begin errors++; $display("FAIL rdi_addr_stable: got %h expected 0000000000003010", imem_addr_o); end
    wait_issues(1, 30, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rdi_new_issue_timeout: got %0d requests expected 1", issue_q.size());
    end else begin
      checks++; if (issue_q[0] !== 64'h1000) begin errors++; $display("FAIL rdi_new_addr: got %h expected 0000000000001000", issue_q[0]); end
    end
    instr_ready_i = 1'b1;
    wait_valid(30, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rdi_valid_timeout: no word after redirect");
    end else begin
      checks++; if (instr_pc_o !== 64'h1000) begin errors++; $display("FAIL rdi_head_pc: got %h expected 0000000000001000", instr_pc_o); end
      checks++; if (instr_o !== mem_word(64'h1000)) begin errors++; $display("FAIL rdi_head_word: got %h expected %h", instr_o, mem_word(64'h1000)); end
    end
    $display("test_redirect_inflight done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_redirect_on_ack;
    bit ok;
    instr_ready_i = 1'b1;
    mem_lat       = 2;
    do_redirect(64'h4000);
    wait_issues(1, 30, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rda_issue_timeout: got %0d requests expected 1", issue_q.size());
    end
    @(negedge clk_i);
    checks++; if (imem_ack_i !== 1'b1) begin errors++; $display("FAIL rda_ack_cycle: got ack %b expected 1", imem_ack_i); end
    do_redirect(64'h6000);
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rda_req_gap: got %b expected 0", imem_req_o); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL rda_discard: got %b expected 0", instr_valid_o); end
    @(negedge clk_i);
    checks++; if (imem_req_o !== 1'b1) begin errors++; $display("FAIL rda_req_next: got %b expected 1", imem_req_o); end
    checks++; if (imem_addr_o !== 64'h6000) begin errors++; $display("FAIL rda_addr_next: got %h expected 0000000000006000", imem_addr_o); end
    wait_valid(20, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL rda_valid_timeout: no word after redirect");
    end else begin
      checks++; if (instr_pc_o !== 64'h6000) begin errors++; $display("FAIL rda_head_pc: got %h expected 0000000000006000", instr_pc_o); end
    end
    $display("test_redirect_on_ack done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_wrap;
    bit          ok;
    logic [63:0] exp_pc;
    instr_ready_i = 1'b1;
    mem_lat       = 1;
    do_redirect(64'hFFFF_FFFF_FFFF_FFFC);
    for (int k = 0; k < 2; k++) begin
      exp_pc = (k == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : 64'h0;
      wait_valid(20, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL wrap_valid_timeout: word %0d never valid", k);
      end else begin
        checks++; if (instr_pc_o !== exp_pc) begin errors++; $display("FAIL wrap_head_pc: got %h expected %h", instr_pc_o, exp_pc); end
      end
      @(negedge clk_i);
    end
    checks++;
    if (issue_q.size() < 2) begin
      errors++; $display("FAIL wrap_req_count: got %0d expected at least 2", issue_q.size());
    end else begin
      checks++; if (issue_q[0] !== 64'hFFFF_FFFF_FFFF_FFF8) begin errors++; $display("FAIL wrap_addr0: got %h expected fffffffffffffff8", issue_q[0]); end
      checks++; if (issue_q[1] !== 64'h0) begin errors++; $display("FAIL wrap_addr1: got %h expected 0000000000000000", issue_q[1]); end
    end
    $display("test_wrap done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_async_reset;
    bit ok;
    instr_ready_i = 1'b0;
    mem_lat       = 4;
    boot_addr_i   = 64'h0000_0000_0000_0104;
    do_redirect(64'h7000);
    wait_issues(2, 40, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL ar_issue_timeout: got %0d requests expected 2", issue_q.size());
    end
    checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL ar_valid_before: got %b expected 1", instr_valid_o); end
`ifdef RV_FETCH_PERF_EN
    checks++; if (fetch_flush_cnt_o !== 32'(flush_total)) begin errors++; $display("FAIL ar_flush_cnt: got %0d expected %0d", fetch_flush_cnt_o, flush_total); end
`endif
    #2;
    arst_ni = 1'b0;
    #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL ar_req: got %b expected 0", imem_req_o); end
    checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b expected 0", instr_valid_o); end
    checks++; if (imem_addr_o !== 64'h0) begin errors++; $display("FAIL ar_addr: got %h expected 0", imem_addr_o); end
    checks++; if (instr_pc_o !== 64'h0) begin errors++; $display("FAIL ar_pc: got %h expected 0", instr_pc_o); end
    checks++; if (instr_o !== 64'h0) begin errors++; $display("FAIL ar_instr: got %h expected 0", instr_o); end
`ifdef RV_FETCH_PERF_EN
    checks++; if (fetch_stall_cnt_o !== 32'h0) begin errors++; $display("FAIL ar_stall_cnt: got %0d expected 0", fetch_stall_cnt_o); end
    checks++; if (fetch_flush_cnt_o !== 32'h0) begin errors++; $display("FAIL ar_flush_cnt0: got %0d expected 0", fetch_flush_cnt_o); end
`endif
    repeat (2) @(negedge clk_i);
    arst_ni = 1'b1;
    issue_q.delete();
    wait_issues(1, 20, ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL ar_restart_timeout: got %0d requests expected 1", issue_q.size());
    end else begin
      checks++; if (issue_q[0] !== 64'h100) begin errors++; $display("FAIL ar_restart_addr: got %h expected 0000000000000100", issue_q[0]); end
    end
    $display("test_async_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    test_reset();
    test_boot();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_on_ack();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute bound on run time in case the DUT never responds
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
